// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard path: event record,
// controller states, set-2 scan codes and the Tetris action map.
package keyboard_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE,
        DECODE
    } ctl_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_ROTATE = 8'h75;
    localparam logic [7:0] SC_DROP   = 8'h29;

    localparam int ACT_LEFT    = 0;
    localparam int ACT_RIGHT   = 1;
    localparam int ACT_DOWN    = 2;
    localparam int ACT_ROTATE  = 3;
    localparam int ACT_DROP    = 4;
    localparam int NUM_ACTIONS = 5;

    // Arrow keys live in the extended page; drop is the plain space bar.
    function automatic logic [NUM_ACTIONS-1:0] action_mask(input logic ext, input logic [7:0] code);
        action_mask = '0;
        if (ext) begin
            case (code)
                SC_LEFT:   action_mask[ACT_LEFT]   = 1'b1;
                SC_RIGHT:  action_mask[ACT_RIGHT]  = 1'b1;
                SC_DOWN:   action_mask[ACT_DOWN]   = 1'b1;
                SC_ROTATE: action_mask[ACT_ROTATE] = 1'b1;
                default:   action_mask = '0;
            endcase
        end else if (code == SC_DROP) begin
            action_mask[ACT_DROP] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO for key events; a pop frees a slot for a push in
// the same cycle, and the head reads as zero while empty.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clock50,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // The extra wrap bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock50) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keyboard_controller.sv
// PS/2 receiver sequencer: read/clear handshake, set-2 prefix assembly,
// key-event FIFO and debounced held/press levels for the Tetris actions.
module keyboard_controller
    import keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int READ_HOLD   = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clock50,
    input  logic        reset_n,
    input  logic        scan_ready,
    input  logic [7:0]  scan_code,
    output logic        read,
    output logic        evt_valid,
    output logic [9:0]  evt_data,
    input  logic        evt_ready,
    output logic [4:0]  held,
    output logic [4:0]  press,
    output logic        overflow,
    output logic        timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(READ_HOLD - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(ACK_TIMEOUT - 1);

    ctl_state_t       state;
    ctl_state_t       state_next;
    logic             sr_m;
    logic             sr_s;
    logic [CW-1:0]    cnt;
    logic [7:0]       code_q;
    logic             abort;
    logic             abort_q;
    logic             ext_f;
    logic             brk_f;
    logic             emit;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [4:0]       mask;
    key_evt_t         evt;

    assign emit      = (state == DECODE) && (code_q != SC_EXT) && (code_q != SC_BRK);
    assign evt       = {brk_f, ext_f, code_q};
    assign mask      = action_mask(ext_f, code_q);
    assign evt_valid = !fifo_empty;
    assign pop       = evt_ready && evt_valid;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Normal release wins over abort on the last allowed ACK cycle.
    always_comb begin
        state_next = state;
        read       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (sr_s) state_next = ACK;
            end
            ACK: begin
                read = 1'b1;
                if (cnt >= HOLD_LAST && !sr_s) begin
                    state_next = RELEASE;
                end else if (cnt == TMO_LAST) begin
                    abort      = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = abort_q ? IDLE : DECODE;
            DECODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            sr_m     <= 1'b0;
            sr_s     <= 1'b0;
            cnt      <= '0;
            code_q   <= '0;
            abort_q  <= 1'b0;
            ext_f    <= 1'b0;
            brk_f    <= 1'b0;
            held     <= '0;
            press    <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            sr_m    <= scan_ready;
            sr_s    <= sr_m;
            timeout <= abort;
            press   <= '0;
            cnt     <= (state == ACK) ? cnt + 1'b1 : '0;
            if (state == IDLE && sr_s) code_q  <= scan_code;
            if (state == ACK)          abort_q <= abort;
            if (abort) begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
            if (state == DECODE) begin
                if (code_q == SC_EXT) begin
                    ext_f <= 1'b1;
                end else if (code_q == SC_BRK) begin
                    brk_f <= 1'b1;
                end else begin
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                    if (brk_f) begin
                        held <= held & ~mask;
                    end else begin
                        held  <= held | mask;
                        press <= mask & ~held;
                    end
                    if (fifo_full && !pop) overflow <= 1'b1;
                end
            end
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_evt_t))
    ) u_fifo (
        .clock50 (clock50),
        .reset_n (reset_n),
        .push    (emit),
        .pop     (pop),
        .din     (evt),
        .head    (evt_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_keyboard_controller.sv
// Scoreboard bench for keyboard_controller: a byte-stream reference model
// predicts events and action levels; a monitor checks what the DUT presents.
module tb_keyboard_controller;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int TMO   = 1024;

    logic       clock50    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       scan_ready = 1'b0;
    logic [7:0] scan_code  = 8'h00;
    logic       evt_ready  = 1'b0;
    logic       read;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic [4:0] held;
    logic [4:0] press;
    logic       overflow;
    logic       timeout;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;
    logic       m_ov   = 1'b0;
    logic [4:0] m_held = '0;
    logic [4:0] press_or = '0;
    int         press_cycles = 0;
    int         pop_cnt = 0;
    int         tmo_cnt = 0;
    int         ready_mode = 0;
    logic [8:0] act_key [5] = '{9'h16B, 9'h174, 9'h172, 9'h175, 9'h029};
    logic [7:0] pool [8]    = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h1C};

    always #5 clock50 = ~clock50;

    keyboard_controller #(
        .FIFO_DEPTH  (DEPTH),
        .READ_HOLD   (HOLD),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clock50    (clock50),
        .reset_n    (reset_n),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .read       (read),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .held       (held),
        .press      (press),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model_mask(input logic ext, input logic [7:0] code);
        model_mask = '0;
        for (int i = 0; i < 5; i++)
            if (act_key[i] == {ext, code}) model_mask[i] = 1'b1;
    endfunction

    // Consumer side: mode 0 stalls, 1 always ready, 2 random.
    initial begin
        forever begin
            @(posedge clock50);
            #2;
            case (ready_mode)
                0:       evt_ready = 1'b0;
                1:       evt_ready = 1'b1;
                default: evt_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clock50);
            if (reset_n) begin
                press_or = press_or | press;
                if (press != 0) press_cycles++;
                if (timeout) tmo_cnt++;
                if (evt_valid && evt_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_event: got 0x%0h, expected no event", evt_data);
                    end else begin
                        check_output("evt_data", {22'd0, evt_data}, {22'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // One full receiver handshake for one byte; pop_plan asserts evt_ready
    // exactly in the cycle the resulting event is pushed.
    task automatic apply_stimulus(input logic [7:0] code, input bit pop_plan);
        logic [4:0] mask;
        logic [4:0] exp_press;
        int k;
        int n;
        int d;
        exp_press = '0;
        if (code == 8'hE0) begin
            m_ext = 1'b1;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            mask = model_mask(m_ext, code);
            if (exp_q.size() < DEPTH || pop_plan) exp_q.push_back({m_brk, m_ext, code});
            else m_ov = 1'b1;
            if (m_brk) begin
                m_held = m_held & ~mask;
            end else begin
                exp_press = mask & ~m_held;
                m_held    = m_held | mask;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        press_or     = '0;
        press_cycles = 0;
        @(posedge clock50);
        #1;
        scan_code  = code;
        scan_ready = 1'b1;
        k = 0;
        do begin
            @(posedge clock50);
            #1;
            k++;
        end while (!read && k < 20);
        check_output("read_latency", k, 3);
        d = $urandom_range(0, 3);
        n = 0;
        if (d == 0) scan_ready = 1'b0;
        do begin
            @(posedge clock50);
            #1;
            n++;
            if (n == d) scan_ready = 1'b0;
        end while (read && n < 2 * TMO);
        scan_ready = 1'b0;
        check_output("read_hold", {31'd0, n >= HOLD}, 1);
        @(posedge clock50);
        #1;
        if (pop_plan) ready_mode = 1;
        @(posedge clock50);
        #1;
        if (pop_plan) ready_mode = 0;
        @(posedge clock50);
        #1;
        check_output("press", {27'd0, press_or}, {27'd0, exp_press});
        check_output("press_cycles", press_cycles, (exp_press != 0) ? 1 : 0);
        check_output("held", {27'd0, held}, {27'd0, m_held});
        check_output("overflow", {31'd0, overflow}, {31'd0, m_ov});
    endtask

    initial begin
        int k;
        int n;
        int idx;
        logic [7:0] code;

        repeat (3) @(posedge clock50);
        #1;
        check_output("reset_outputs", {14'd0, read, evt_valid, evt_data, held, press, overflow, timeout}, 0);
        reset_n = 1'b1;
        ready_mode = 1;

        $display("[TB] single make code");
        ready_mode = 0;
        apply_stimulus(8'h1C, 0);
        check_output("evt_valid_1c", {31'd0, evt_valid}, 1);
        check_output("evt_head_1c", {22'd0, evt_data}, 32'h01C);
        ready_mode = 1;
        repeat (3) @(posedge clock50);

        $display("[TB] extended make, repeat and break");
        apply_stimulus(8'hE0, 0);
        apply_stimulus(8'h6B, 0);
        apply_stimulus(8'hE0, 0);
        apply_stimulus(8'h6B, 0);
        apply_stimulus(8'hE0, 0);
        apply_stimulus(8'hF0, 0);
        apply_stimulus(8'h6B, 0);

        $display("[TB] randomized byte stream");
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(0, 8);
            code = (idx == 8) ? 8'($urandom_range(0, 255)) : pool[idx];
            apply_stimulus(code, 0);
        end
        ready_mode = 1;
        repeat (6) @(posedge clock50);
        #1;
        check_output("drained_random", exp_q.size(), 0);

        $display("[TB] push into full FIFO with simultaneous pop");
        ready_mode = 0;
        apply_stimulus(8'h1C, 0);
        apply_stimulus(8'h32, 0);
        apply_stimulus(8'h21, 0);
        apply_stimulus(8'h23, 0);
        pop_cnt = 0;
        apply_stimulus(8'h2A, 1);
        ready_mode = 1;
        repeat (8) @(posedge clock50);
        #1;
        check_output("full_pop_count", pop_cnt, 5);

        $display("[TB] overflow with stalled consumer");
        apply_stimulus(8'hF0, 0);
        apply_stimulus(8'h29, 0);
        repeat (4) @(posedge clock50);
        ready_mode = 0;
        apply_stimulus(8'h1C, 0);
        apply_stimulus(8'h32, 0);
        apply_stimulus(8'h21, 0);
        apply_stimulus(8'h23, 0);
        apply_stimulus(8'h29, 0);
        pop_cnt = 0;
        ready_mode = 1;
        repeat (8) @(posedge clock50);
        #1;
        check_output("overflow_drain_count", pop_cnt, 4);

        $display("[TB] stuck scan_ready");
        tmo_cnt = 0;
        apply_stimulus(8'hE0, 0);
        @(posedge clock50);
        #1;
        scan_code  = 8'h74;
        scan_ready = 1'b1;
        k = 0;
        do begin
            @(posedge clock50);
            #1;
            k++;
        end while (!read && k < 20);
        n = 0;
        do begin
            @(posedge clock50);
            #1;
            n++;
            if (n == TMO - 1) scan_ready = 1'b0;
        end while (!timeout && n < TMO + 10);
        scan_ready = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_output("timeout_delay", n, TMO);
        check_output("read_after_abort", {31'd0, read}, 0);
        repeat (5) @(posedge clock50);
        #1;
        check_output("timeout_pulses", tmo_cnt, 1);
        check_output("no_event_after_abort", {31'd0, evt_valid}, 0);
        apply_stimulus(8'h1C, 0);

        $display("[TB] reset during ACK");
        ready_mode = 0;
        apply_stimulus(8'h1C, 0);
        @(posedge clock50);
        #1;
        scan_code  = 8'h75;
        scan_ready = 1'b1;
        k = 0;
        do begin
            @(posedge clock50);
            #1;
            k++;
        end while (!read && k < 20);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("read_in_reset", {31'd0, read}, 0);
        check_output("outputs_in_reset", {14'd0, read, evt_valid, evt_data, held, press, overflow, timeout}, 0);
        exp_q.delete();
        m_held = '0;
        m_ov   = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        scan_ready = 1'b0;
        ready_mode = 1;
        repeat (3) @(posedge clock50);
        #1;
        reset_n = 1'b1;
        apply_stimulus(8'h29, 0);
        repeat (4) @(posedge clock50);
        #1;
        check_output("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
